// File: rtl/ex_defs.sv
// Shared definitions for the execute stage: ALU_OP codes,
// decoded funct values and multiplier FSM state encoding.
package ex_defs;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/multu_seq.sv
// Iterative 32-cycle shift-add unsigned multiplier.
// Ports: clk, rst_n, start, src, tar in; busy (stall), done, product out.
module multu_seq
    import ex_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src,
    input  logic [31:0] tar,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    mul_state_e  state, state_nx;
    logic [4:0]  cnt;
    logic [64:0] p;
    logic [31:0] mcand;
    logic [32:0] sum;
    logic [64:0] p_shift;

    always_comb begin
        sum     = p[0] ? (p[64:32] + {1'b0, mcand}) : p[64:32];
        p_shift = {1'b0, sum, p[31:1]};
    end

    // done strobes in the last MUL cycle so the owner of HI/LO
    // captures the post-shift product on the edge leaving MUL.
    assign done    = (state == S_MUL) && (cnt == 5'd31);
    assign product = p_shift[63:0];
    assign busy    = ((state == S_IDLE) && start) || (state == S_MUL);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_MUL;
            S_MUL:   if (cnt == 5'd31) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            p     <= '0;
            mcand <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                mcand <= src;
                p     <= {33'b0, tar};
                cnt   <= '0;
            end else if (state == S_MUL) begin
                p   <= p_shift;
                cnt <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU decode/mux, HI/LO, MULTU control, EX/WB register.
// Ports: ID/EX fields in; registered wb/dst/result and stall_out out.
module ex_stage
    import ex_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_in,
    input  logic [1:0]  ALU_OP_in,
    input  logic [31:0] src_data_in,
    input  logic [31:0] tar_data_in,
    input  logic [4:0]  shamt_in,
    input  logic [4:0]  dst_addr_in,
    input  logic [5:0]  funct_ctrl_in,
    output logic        wb_out,
    output logic [4:0]  dst_addr_out,
    output logic [31:0] result_out,
    output logic        stall_out
);

    logic [31:0] hi, lo;
    logic [31:0] alu_res;
    logic        op_ok;
    logic        is_multu;
    logic        rtype;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        wb_ok;

    assign rtype    = (ALU_OP_in == ALU_RTYPE);
    assign is_multu = rtype && (funct_ctrl_in == F_MULTU);

    always_comb begin
        alu_res = '0;
        op_ok   = 1'b1;
        unique case (1'b1)
            (ALU_OP_in == ALU_ADD):
                alu_res = src_data_in + tar_data_in;
            (ALU_OP_in == ALU_SUB):
                alu_res = src_data_in - tar_data_in;
            (rtype && funct_ctrl_in == F_ADDU):
                alu_res = src_data_in + tar_data_in;
            (rtype && funct_ctrl_in == F_SUBU):
                alu_res = src_data_in - tar_data_in;
            (rtype && funct_ctrl_in == F_AND):
                alu_res = src_data_in & tar_data_in;
            (rtype && funct_ctrl_in == F_OR):
                alu_res = src_data_in | tar_data_in;
            (rtype && funct_ctrl_in == F_SLL):
                alu_res = tar_data_in << shamt_in;
            (rtype && funct_ctrl_in == F_SRL):
                alu_res = tar_data_in >> shamt_in;
            (rtype && funct_ctrl_in == F_MFHI):
                alu_res = hi;
            (rtype && funct_ctrl_in == F_MFLO):
                alu_res = lo;
            default:
                op_ok = 1'b0;
        endcase
    end

    multu_seq u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (is_multu),
        .src     (src_data_in),
        .tar     (tar_data_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    assign stall_out = busy;

    // MULTU itself never writes the register file; it only updates HI/LO.
    assign wb_ok = op_ok && !is_multu && (dst_addr_in != 5'd0) && !busy;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            hi <= product[63:32];
            lo <= product[31:0];
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_out       <= 1'b0;
            dst_addr_out <= '0;
            result_out   <= '0;
        end else begin
            wb_out       <= wb_in && wb_ok;
            dst_addr_out <= busy ? 5'd0 : dst_addr_in;
            result_out   <= wb_ok ? alu_res : 32'd0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Inputs change #1 after posedge; outputs sampled there too.
module tb_ex_stage;
    import ex_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_in;
    logic [1:0]  alu_op;
    logic [31:0] src, tar;
    logic [4:0]  shamt, dst;
    logic [5:0]  funct;
    logic        wb_out;
    logic [4:0]  dst_out;
    logic [31:0] res_out;
    logic        stall;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_in         (wb_in),
        .ALU_OP_in     (alu_op),
        .src_data_in   (src),
        .tar_data_in   (tar),
        .shamt_in      (shamt),
        .dst_addr_in   (dst),
        .funct_ctrl_in (funct),
        .wb_out        (wb_out),
        .dst_addr_out  (dst_out),
        .result_out    (res_out),
        .stall_out     (stall)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic w, input logic [1:0] op,
                          input logic [31:0] s, input logic [31:0] t,
                          input logic [4:0] sh, input logic [4:0] d,
                          input logic [5:0] f);
        wb_in  = w;
        alu_op = op;
        src    = s;
        tar    = t;
        shamt  = sh;
        dst    = d;
        funct  = f;
    endtask

    // Leaves the bench in the DONE cycle, MULTU still at the input.
    task automatic run_multu(input logic [31:0] a, input logic [31:0] b,
                             output int cycles, output logic wb_bad);
        int n;
        n = 0;
        wb_bad = 1'b0;
        set_in(1'b1, 2'b10, a, b, 5'd0, 5'd3, F_MULTU);
        #1;
        while (stall && n < 40) begin
            n++;
            step();
            if (wb_out !== 1'b0 || res_out !== 32'd0) wb_bad = 1'b1;
        end
        cycles = n;
    endtask

    task automatic test_reset;
        set_in(1'b0, 2'b11, 32'd0, 32'd0, 5'd0, 5'd0, 6'd0);
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (wb_out !== 1'b0 || dst_out !== 5'd0 || res_out !== 32'd0 || stall !== 1'b0) begin
            errs++;
            $display("FAIL reset_init: wb=%b dst=%0d res=%h stall=%b, want all 0",
                     wb_out, dst_out, res_out, stall);
        end
        #1 rst_n = 1'b1;
        step();
        set_in(1'b1, 2'b10, 32'd1, 32'd1, 5'd0, 5'd7, F_ADDU);
        step();
        checks++;
        if (res_out !== 32'd2 || wb_out !== 1'b1 || dst_out !== 5'd7) begin
            errs++;
            $display("FAIL pre_reset_addu: res=%h wb=%b dst=%0d, want 2 1 7",
                     res_out, wb_out, dst_out);
        end
        rst_n = 1'b0;
        set_in(1'b0, 2'b11, 32'd0, 32'd0, 5'd0, 5'd0, 6'd0);
        #1;
        checks++;
        if (wb_out !== 1'b0 || dst_out !== 5'd0 || res_out !== 32'd0 || stall !== 1'b0) begin
            errs++;
            $display("FAIL reset_async: wb=%b dst=%0d res=%h stall=%b, want all 0",
                     wb_out, dst_out, res_out, stall);
        end
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] s;
        logic [31:0] t;
        logic [4:0]  sh;
        logic [4:0]  d;
        logic [31:0] exp;
    } vec_t;

    task automatic test_alu;
        vec_t v[8];
        v[0] = '{2'b10, F_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd5, 32'h0000_0000};
        v[1] = '{2'b10, F_SUBU, 32'h0, 32'h1, 5'd0, 5'd6, 32'hFFFF_FFFF};
        v[2] = '{2'b10, F_SLL, 32'h1234_5678, 32'h1, 5'd31, 5'd7, 32'h8000_0000};
        v[3] = '{2'b10, F_SRL, 32'h0, 32'h8000_0000, 5'd4, 5'd8, 32'h0800_0000};
        v[4] = '{2'b10, F_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd0, 5'd9, 32'h3030_3030};
        v[5] = '{2'b10, F_OR, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 5'd10, 32'hFFFF_F0F0};
        v[6] = '{2'b00, 6'h3F, 32'd2, 32'd3, 5'd0, 5'd11, 32'd5};
        v[7] = '{2'b01, 6'h3F, 32'd5, 32'd7, 5'd0, 5'd31, 32'hFFFF_FFFE};
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, v[i].op, v[i].s, v[i].t, v[i].sh, v[i].d, v[i].f);
            step();
            checks++;
            if (res_out !== v[i].exp || wb_out !== 1'b1 || dst_out !== v[i].d) begin
                errs++;
                $display("FAIL alu[%0d]: res=%h wb=%b dst=%0d, want %h 1 %0d",
                         i, res_out, wb_out, dst_out, v[i].exp, v[i].d);
            end
        end
    endtask

    task automatic test_suppress;
        set_in(1'b1, 2'b10, 32'd4, 32'd4, 5'd0, 5'd5, 6'h3F);
        step();
        checks++;
        if (wb_out !== 1'b0 || res_out !== 32'd0) begin
            errs++;
            $display("FAIL bad_funct: wb=%b res=%h, want 0 0", wb_out, res_out);
        end
        set_in(1'b1, 2'b10, 32'd4, 32'd4, 5'd0, 5'd0, F_ADDU);
        step();
        checks++;
        if (wb_out !== 1'b0 || res_out !== 32'd0) begin
            errs++;
            $display("FAIL dst_zero: wb=%b res=%h, want 0 0", wb_out, res_out);
        end
        set_in(1'b1, 2'b11, 32'd4, 32'd4, 5'd0, 5'd5, F_ADDU);
        step();
        checks++;
        if (wb_out !== 1'b0 || res_out !== 32'd0) begin
            errs++;
            $display("FAIL op_rsvd: wb=%b res=%h, want 0 0", wb_out, res_out);
        end
        set_in(1'b0, 2'b10, 32'd4, 32'd4, 5'd0, 5'd5, F_ADDU);
        step();
        checks++;
        if (wb_out !== 1'b0 || dst_out !== 5'd5) begin
            errs++;
            $display("FAIL wb_in_low: wb=%b dst=%0d, want 0 5", wb_out, dst_out);
        end
    endtask

    task automatic test_multu_max;
        int n;
        logic bad;
        run_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, n, bad);
        checks++;
        if (n !== 33 || bad !== 1'b0) begin
            errs++;
            $display("FAIL multu_stall: cycles=%0d wb_seen=%b, want 33 0", n, bad);
        end
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd12, F_MFHI);
        step();
        checks++;
        if (res_out !== 32'hFFFF_FFFE || wb_out !== 1'b1 || dst_out !== 5'd12) begin
            errs++;
            $display("FAIL mfhi_max: res=%h wb=%b dst=%0d, want fffffffe 1 12",
                     res_out, wb_out, dst_out);
        end
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd13, F_MFLO);
        step();
        checks++;
        if (res_out !== 32'h0000_0001 || wb_out !== 1'b1) begin
            errs++;
            $display("FAIL mflo_max: res=%h wb=%b, want 00000001 1", res_out, wb_out);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic bad;
        run_multu(32'd3, 32'd5, n, bad);
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd14, F_MFLO);
        step();
        checks++;
        if (res_out !== 32'd15 || n !== 33) begin
            errs++;
            $display("FAIL mflo_3x5: res=%0d cycles=%0d, want 15 33", res_out, n);
        end
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd14, F_MFHI);
        step();
        checks++;
        if (res_out !== 32'd0) begin
            errs++;
            $display("FAIL mfhi_3x5: res=%h, want 0", res_out);
        end
        run_multu(32'd7, 32'd0, n, bad);
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd15, F_MFLO);
        step();
        checks++;
        if (res_out !== 32'd0 || n !== 33) begin
            errs++;
            $display("FAIL mflo_7x0: res=%h cycles=%0d, want 0 33", res_out, n);
        end
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd15, F_MFHI);
        step();
        checks++;
        if (res_out !== 32'd0) begin
            errs++;
            $display("FAIL mfhi_7x0: res=%h, want 0", res_out);
        end
    endtask

    task automatic test_reset_mid_mul;
        int n;
        logic bad;
        run_multu(32'd3, 32'd5, n, bad);
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd16, F_MFLO);
        step();
        checks++;
        if (res_out !== 32'd15) begin
            errs++;
            $display("FAIL mflo_pre_abort: res=%0d, want 15", res_out);
        end
        set_in(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd3, F_MULTU);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (stall !== 1'b1) begin
            errs++;
            $display("FAIL stall_mid_mul: stall=%b, want 1", stall);
        end
        rst_n = 1'b0;
        set_in(1'b0, 2'b11, 32'd0, 32'd0, 5'd0, 5'd0, 6'd0);
        #1;
        checks++;
        if (wb_out !== 1'b0 || dst_out !== 5'd0 || res_out !== 32'd0 || stall !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid_mul: wb=%b dst=%0d res=%h stall=%b, want all 0",
                     wb_out, dst_out, res_out, stall);
        end
        #1 rst_n = 1'b1;
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd17, F_MFLO);
        step();
        checks++;
        if (res_out !== 32'd0 || wb_out !== 1'b1 || stall !== 1'b0) begin
            errs++;
            $display("FAIL mflo_after_abort: res=%h wb=%b stall=%b, want 0 1 0",
                     res_out, wb_out, stall);
        end
        set_in(1'b1, 2'b10, 32'd0, 32'd0, 5'd0, 5'd17, F_MFHI);
        step();
        checks++;
        if (res_out !== 32'd0) begin
            errs++;
            $display("FAIL mfhi_after_abort: res=%h, want 0", res_out);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_suppress();
        test_multu_max();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
